// File: rtl/stm32_iq_stream_if_if.sv
// Bundle of the IQ frame input, STM32 command/bus side and status outputs of stm32_iq_stream_if.
// The master modport drives frames and commands; the slave modport is the streaming block.
interface stm32_iq_stream_if_if #(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned SAMPLE_BYTES = 4,
    parameter int unsigned FIFO_DEPTH   = 8
) ();
    localparam int unsigned FRAME_W = CHANNELS * 2 * 8 * SAMPLE_BYTES;
    localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;

    logic                iq_valid_in;
    logic [FRAME_W-1:0]  iq_data_in;
    logic                sync_in;
    logic [7:0]          bus_in;
    logic [7:0]          bus_out;
    logic                bus_oe;
    logic [CHANNELS-1:0] chan_mask;
    logic [LVL_W-1:0]    fifo_level;
    logic                overflow;
    logic                underrun;

    modport master (
        output iq_valid_in, iq_data_in, sync_in, bus_in,
        input  bus_out, bus_oe, chan_mask, fifo_level, overflow, underrun
    );

    modport slave (
        input  iq_valid_in, iq_data_in, sync_in, bus_in,
        output bus_out, bus_oe, chan_mask, fifo_level, overflow, underrun
    );
endinterface

// File: rtl/stm32_iq_stream_if.sv
// Buffers multi-channel IQ frames in a FIFO and streams them byte-wise to the STM32 bus,
// with channel masking, overflow/underrun flags, saturating drop counter and status readback.
module stm32_iq_stream_if #(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned SAMPLE_BYTES = 4,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    stm32_iq_stream_if_if.slave   io
);
    localparam int unsigned SAMPLE_W = 8 * SAMPLE_BYTES;
    localparam int unsigned CH_BYTES = 2 * SAMPLE_BYTES;
    localparam int unsigned FRAME_W  = CHANNELS * 2 * SAMPLE_W;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W    = PTR_W + 1;
    localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned BYTE_W   = $clog2(CH_BYTES);
    localparam int unsigned BIT_W    = $clog2(FRAME_W);

    localparam logic [7:0] CMD_STREAM  = 8'h04;
    localparam logic [7:0] CMD_STATUS  = 8'h09;
    localparam logic [7:0] CMD_SETMASK = 8'h0A;
    localparam logic [7:0] CMD_CLEAR   = 8'h0B;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_STATUS, S_SETMASK} state_e;

    state_e              state_q, state_d;
    logic [7:0]          bus_out_q, bus_out_d;
    logic                bus_oe_q, bus_oe_d;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic [CHANNELS-1:0] fmask_q, fmask_d;
    logic [FRAME_W-1:0]  hold_q, hold_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [BYTE_W-1:0]   b_q, b_d;
    logic                start_q, start_d;
    logic [1:0]          st_idx_q, st_idx_d;

    logic [FRAME_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]    level_q;
    logic                overflow_q, underrun_q;
    logic [7:0]          ovf_cnt_q;

    logic full, empty, pop, push, drop, unr_set, clr_flags;

    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign push  = io.iq_valid_in && (!full || pop);
    assign drop  = io.iq_valid_in && full && !pop;

    // Stream datapath: at frame start the byte comes straight from the FIFO head (or zero).
    logic [CHANNELS-1:0] eff_mask, cur_mask;
    logic [FRAME_W-1:0]  cur_frame;
    logic [CH_W-1:0]     first_ch, cur_ch, nxt_ch;
    logic                nxt_found, last_byte;
    logic [BYTE_W-1:0]   cur_b, bn;
    logic [BIT_W-1:0]    sel_bit;
    logic [7:0]          cur_byte;

    always_comb begin
        eff_mask  = (mask_q == '0) ? CHANNELS'(1) : mask_q;
        cur_mask  = start_q ? eff_mask : fmask_q;
        cur_frame = start_q ? (empty ? '0 : mem_q[rd_ptr_q]) : hold_q;
        first_ch  = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (cur_mask[CH_W'(i)]) first_ch = CH_W'(i);
        end
        cur_ch    = start_q ? first_ch : ch_q;
        cur_b     = start_q ? '0 : b_q;
        nxt_ch    = '0;
        nxt_found = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (cur_mask[CH_W'(i)] && (i > int'(cur_ch))) begin
                nxt_ch    = CH_W'(i);
                nxt_found = 1'b1;
            end
        end
        // Q bytes MSB first (low half), then I bytes MSB first (high half); modular math is exact here.
        bn        = (cur_b < BYTE_W'(SAMPLE_BYTES)) ? (BYTE_W'(SAMPLE_BYTES - 1) - cur_b)
                                                    : (BYTE_W'(3 * SAMPLE_BYTES - 1) - cur_b);
        sel_bit   = BIT_W'((32'(cur_ch) * CH_BYTES + 32'(bn)) * 8);
        cur_byte  = cur_frame[sel_bit +: 8];
        last_byte = (cur_b == BYTE_W'(CH_BYTES - 1));
    end

    // Next-state and output decode; sync_in overrides whatever state we are in.
    always_comb begin
        state_d   = state_q;
        bus_out_d = bus_out_q;
        bus_oe_d  = bus_oe_q;
        mask_d    = mask_q;
        fmask_d   = fmask_q;
        hold_d    = hold_q;
        ch_d      = ch_q;
        b_d       = b_q;
        start_d   = start_q;
        st_idx_d  = st_idx_q;
        pop       = 1'b0;
        unr_set   = 1'b0;
        clr_flags = 1'b0;

        if (io.sync_in) begin
            case (io.bus_in)
                CMD_STREAM: begin
                    state_d  = S_STREAM;
                    bus_oe_d = 1'b1;
                    start_d  = 1'b1;
                end
                CMD_STATUS: begin
                    state_d  = S_STATUS;
                    bus_oe_d = 1'b1;
                    st_idx_d = '0;
                end
                CMD_SETMASK: begin
                    state_d  = S_SETMASK;
                    bus_oe_d = 1'b0;
                end
                CMD_CLEAR: begin
                    clr_flags = 1'b1;
                    state_d   = S_IDLE;
                    bus_oe_d  = 1'b0;
                end
                default: begin
                    state_d  = S_IDLE;
                    bus_oe_d = 1'b0;
                end
            endcase
        end else begin
            case (state_q)
                S_IDLE: bus_oe_d = 1'b0;
                S_SETMASK: begin
                    mask_d   = io.bus_in[CHANNELS-1:0];
                    state_d  = S_IDLE;
                    bus_oe_d = 1'b0;
                end
                S_STREAM: begin
                    bus_out_d = cur_byte;
                    if (start_q) begin
                        pop     = !empty;
                        unr_set = empty;
                        hold_d  = cur_frame;
                        fmask_d = cur_mask;
                    end
                    start_d = 1'b0;
                    if (last_byte) begin
                        b_d = '0;
                        if (nxt_found) ch_d = nxt_ch;
                        else           start_d = 1'b1;
                    end else begin
                        b_d  = cur_b + BYTE_W'(1);
                        ch_d = cur_ch;
                    end
                end
                S_STATUS: begin
                    case (st_idx_q)
                        2'd0:    bus_out_d = {5'b0, underrun_q, overflow_q, full};
                        2'd1:    bus_out_d = 8'(level_q);
                        default: bus_out_d = ovf_cnt_q;
                    endcase
                    st_idx_d = st_idx_q + 2'd1;
                    if (st_idx_q == 2'd2) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= S_IDLE;
            bus_out_q <= '0;
            bus_oe_q  <= 1'b0;
            mask_q    <= '1;
            fmask_q   <= '1;
            hold_q    <= '0;
            ch_q      <= '0;
            b_q       <= '0;
            start_q   <= 1'b0;
            st_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            bus_out_q <= bus_out_d;
            bus_oe_q  <= bus_oe_d;
            mask_q    <= mask_d;
            fmask_q   <= fmask_d;
            hold_q    <= hold_d;
            ch_q      <= ch_d;
            b_q       <= b_d;
            start_q   <= start_d;
            st_idx_q  <= st_idx_d;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      level_q <= level_q + LVL_W'(1);
            else if (pop && !push) level_q <= level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q] <= io.iq_data_in;
    end

    // Sticky flags and saturating drop counter.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
            ovf_cnt_q  <= '0;
        end else if (clr_flags) begin
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
                if (ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
            end
            if (unr_set) underrun_q <= 1'b1;
        end
    end

    assign io.bus_out    = bus_out_q;
    assign io.bus_oe     = bus_oe_q;
    assign io.chan_mask  = mask_q;
    assign io.fifo_level = level_q;
    assign io.overflow   = overflow_q;
    assign io.underrun   = underrun_q;
endmodule

// File: tb/tb_stm32_iq_stream_if.sv
// Scoreboard bench for stm32_iq_stream_if: a reference FIFO/flag model predicts bus bytes and status.
module tb_stm32_iq_stream_if;
    localparam int unsigned CH      = 2;
    localparam int unsigned SB      = 4;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned SW      = 8 * SB;
    localparam int unsigned FRAME_W = CH * 2 * SW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stm32_iq_stream_if_if #(.CHANNELS(CH), .SAMPLE_BYTES(SB), .FIFO_DEPTH(DEPTH)) io ();

    stm32_iq_stream_if #(.CHANNELS(CH), .SAMPLE_BYTES(SB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in   (clk),
        .reset_in (rst),
        .io       (io)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [FRAME_W-1:0] model_q [$];
    logic [7:0]         exp_q [$];
    logic [CH-1:0]      model_mask;
    logic               model_ovf, model_unr;
    int                 model_cnt;

    localparam logic [FRAME_W-1:0] F1 = {32'hAABBCCDD, 32'h01020304, 32'h11223344, 32'h55667788};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        model_mask = '1;
        model_ovf  = 1'b0;
        model_unr  = 1'b0;
        model_cnt  = 0;
    endtask

    task automatic push_frame(input logic [FRAME_W-1:0] f);
        io.iq_valid_in = 1'b1;
        io.iq_data_in  = f;
        tick();
        io.iq_valid_in = 1'b0;
        if (model_q.size() < DEPTH) model_q.push_back(f);
        else begin
            model_ovf = 1'b1;
            if (model_cnt < 255) model_cnt++;
        end
    endtask

    task automatic command(input logic [7:0] c);
        io.sync_in = 1'b1;
        io.bus_in  = c;
        tick();
        io.sync_in = 1'b0;
        io.bus_in  = 8'h00;
        if (c == 8'h0B) begin
            model_ovf = 1'b0;
            model_unr = 1'b0;
            model_cnt = 0;
        end
    endtask

    task automatic set_mask(input logic [7:0] m);
        command(8'h0A);
        io.bus_in = m;
        tick();
        io.bus_in  = 8'h00;
        model_mask = m[CH-1:0];
    endtask

    // Reference byte order: per enabled channel, Q bytes MSB first then I bytes MSB first.
    task automatic expect_frame(input logic [FRAME_W-1:0] f);
        logic [CH-1:0] m;
        m = (model_mask == '0) ? CH'(1) : model_mask;
        for (int c = 0; c < CH; c++) begin
            if (m[c]) begin
                for (int k = SB - 1; k >= 0; k--) exp_q.push_back(f[c*2*SW + k*8 +: 8]);
                for (int k = SB - 1; k >= 0; k--) exp_q.push_back(f[c*2*SW + SW + k*8 +: 8]);
            end
        end
    endtask

    task automatic drain(input string name);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (io.bus_out !== e || io.bus_oe !== 1'b1) begin
                n_fail++;
                $display("FAIL %s: bus_out=%02h oe=%b, required %02h oe=1", name, io.bus_out, io.bus_oe, e);
            end
        end
    endtask

    task automatic stream_frames(input int n, input string name);
        logic [FRAME_W-1:0] fr;
        command(8'h04);
        n_cmp++;
        if (io.bus_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_oe: bus_oe=%b, required 1", name, io.bus_oe);
        end
        for (int f = 0; f < n; f++) begin
            if (model_q.size() > 0) fr = model_q.pop_front();
            else begin
                fr = '0;
                model_unr = 1'b1;
            end
            expect_frame(fr);
            drain(name);
        end
        n_cmp++;
        if (io.underrun !== model_unr || io.fifo_level !== 4'(model_q.size())) begin
            n_fail++;
            $display("FAIL %s_flags: underrun=%b level=%0d, required underrun=%b level=%0d",
                     name, io.underrun, io.fifo_level, model_unr, model_q.size());
        end
    endtask

    task automatic read_status(input string name);
        command(8'h09);
        exp_q.push_back({5'b0, model_unr, model_ovf, model_q.size() == DEPTH});
        exp_q.push_back(8'(model_q.size()));
        exp_q.push_back(8'(model_cnt));
        drain(name);
        tick();
        n_cmp++;
        if (io.bus_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release: bus_oe=%b, required 0", name, io.bus_oe);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        io.iq_valid_in = 1'b0;
        io.iq_data_in  = '0;
        io.sync_in     = 1'b0;
        io.bus_in      = 8'h00;
        model_reset();
        tick();
        tick();
        n_cmp++;
        if (io.bus_out !== 8'h00 || io.bus_oe !== 1'b0 || io.chan_mask !== 2'b11 ||
            io.fifo_level !== 4'd0 || io.overflow !== 1'b0 || io.underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: out=%02h oe=%b mask=%b lvl=%0d ovf=%b unr=%b, required 00 0 11 0 0 0",
                     io.bus_out, io.bus_oe, io.chan_mask, io.fifo_level, io.overflow, io.underrun);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stream_basic();
        push_frame(F1);
        n_cmp++;
        if (io.fifo_level !== 4'd1) begin
            n_fail++;
            $display("FAIL push_level: level=%0d, required 1", io.fifo_level);
        end
        stream_frames(2, "stream_full_mask");
        n_cmp++;
        if (io.underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_set: underrun=%b, required 1", io.underrun);
        end
    endtask

    task automatic test_mask();
        set_mask(8'h02);
        n_cmp++;
        if (io.chan_mask !== 2'b10 || io.bus_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL setmask: mask=%b oe=%b, required 10 0", io.chan_mask, io.bus_oe);
        end
        push_frame(F1);
        stream_frames(1, "stream_mask_ch1");
        set_mask(8'h00);
        push_frame(F1);
        stream_frames(1, "stream_mask_zero");
        set_mask(8'h03);
    endtask

    task automatic test_overflow();
        command(8'h0B);
        for (int i = 0; i < 11; i++) push_frame({$urandom, $urandom, $urandom, $urandom});
        n_cmp++;
        if (io.fifo_level !== 4'd8 || io.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: level=%0d ovf=%b, required 8 1", io.fifo_level, io.overflow);
        end
        read_status("status_overflow");
    endtask

    task automatic test_simul_push_pop();
        logic [FRAME_W-1:0] nf, head;
        nf   = {$urandom, $urandom, $urandom, $urandom};
        head = model_q[0];
        io.sync_in = 1'b1;
        io.bus_in  = 8'h04;
        tick();
        io.sync_in     = 1'b0;
        io.bus_in      = 8'h00;
        io.iq_valid_in = 1'b1;
        io.iq_data_in  = nf;
        tick();
        io.iq_valid_in = 1'b0;
        void'(model_q.pop_front());
        model_q.push_back(nf);
        n_cmp++;
        if (io.fifo_level !== 4'd8 || io.bus_out !== head[SW-1 -: 8]) begin
            n_fail++;
            $display("FAIL simul_push_pop: level=%0d out=%02h, required 8 %02h",
                     io.fifo_level, io.bus_out, head[SW-1 -: 8]);
        end
        read_status("status_simul");
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) push_frame({$urandom, $urandom, $urandom, $urandom});
        read_status("status_saturated");
        command(8'h0B);
        n_cmp++;
        if (io.overflow !== 1'b0 || io.underrun !== 1'b0 || io.fifo_level !== 4'd8) begin
            n_fail++;
            $display("FAIL clear: ovf=%b unr=%b lvl=%0d, required 0 0 8", io.overflow, io.underrun, io.fifo_level);
        end
        read_status("status_cleared");
    endtask

    task automatic test_reset_mid_stream();
        command(8'h04);
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (io.bus_oe !== 1'b0 || io.fifo_level !== 4'd0 || io.overflow !== 1'b0 ||
            io.underrun !== 1'b0 || io.bus_out !== 8'h00 || io.chan_mask !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_mid: oe=%b lvl=%0d ovf=%b unr=%b out=%02h mask=%b, required 0 0 0 0 00 11",
                     io.bus_oe, io.fifo_level, io.overflow, io.underrun, io.bus_out, io.chan_mask);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        stream_frames(1, "stream_after_reset");
        command(8'hFF);
        tick();
        n_cmp++;
        if (io.bus_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL unknown_cmd: bus_oe=%b, required 0", io.bus_oe);
        end
    endtask

    initial begin
        test_reset();
        test_stream_basic();
        test_mask();
        test_overflow();
        test_simul_push_pop();
        test_saturate();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end
endmodule

// File: doc/stm32_iq_stream_if.md
Name: stm32_iq_stream_if

Overview:
Parametrised successor to the STM32 parallel-bus IQ interface. It buffers multi-channel RX IQ frames in a frame FIFO and streams them byte-wise to the STM32 over the 8-bit bus. It adds a run-time channel-enable mask, overflow and underrun detection with a saturating overflow counter, and a status readback. It sits between the DDC outputs and the top-level DATA_BUS tristate; the tristate itself stays in the top level.

Parameters:
CHANNELS, 2, number of RX channels (1..4); each channel carries one I and one Q sample.
SAMPLE_BYTES, 4, bytes per I or Q sample (1..4); sample width is 8*SAMPLE_BYTES bits.
FIFO_DEPTH, 8, frame FIFO depth; must be a power of 2, range 2..64.

Ports:
clk_in  input  1  interface clock; all logic on its rising edge.
reset_in  input  1  asynchronous, active-high reset.
iq_valid_in  input  1  one-cycle strobe; iq_data_in holds a new frame.
iq_data_in  input  CHANNELS*2*8*SAMPLE_BYTES  frame data; channel c occupies slice c. Within a slice, {I,Q} with Q in the low half.
sync_in  input  1  command strobe from STM32; bus_in carries the command byte.
bus_in  input  8  bus read-back value (DATA_BUS input side).
bus_out  output  8  registered bus drive value.
bus_oe  output  1  1 = FPGA drives the bus.
chan_mask  output  CHANNELS  current channel-enable mask.
fifo_level  output  clog2(FIFO_DEPTH)+1  frames currently stored.
overflow  output  1  sticky flag: a frame was dropped.
underrun  output  1  sticky flag: a zero frame was sent.

Behaviour:
Reset values:
- bus_out=0, bus_oe=0, chan_mask=all ones, fifo_level=0, overflow=0, underrun=0, overflow counter=0.
- State=IDLE; FIFO pointers=0.

FIFO:
- Push on iq_valid_in.
- If full and no pop in the same cycle: drop the incoming frame, set overflow, increment ovf_cnt (8-bit, saturates at 255).
- Simultaneous push and pop: both occur, level unchanged. This holds when full as well, and the push is accepted.
- Pointers wrap modulo FIFO_DEPTH.

Commands (sampled when sync_in=1; sync_in has priority over any state and aborts the current transfer):
- 0x04 STREAM: bus_oe=1 on that edge, state=STREAM.
- 0x09 STATUS: bus_oe=1, state=STATUS.
- 0x0A SETMASK: bus_oe=0; the next non-sync cycle latches chan_mask=bus_in[CHANNELS-1:0], then state=IDLE.
- 0x0B CLEAR: on that edge, clear overflow, underrun and ovf_cnt; state=IDLE, bus_oe=0.
- Any other code: state=IDLE, bus_oe=0.

STREAM:
- At frame start (first non-sync cycle, and each cycle after the last byte of a frame), pop one frame into a hold register if the FIFO is non-empty.
- If the FIFO is empty, load an all-zero frame and set underrun.
- The first frame byte is registered onto bus_out on that same edge; each subsequent non-sync edge presents the next byte.
- Byte order per channel: Q MSB first, then I MSB first, giving 2*SAMPLE_BYTES bytes per channel.
- Channels are sent in ascending index; channels with mask bit 0 are skipped. If the mask is all zero, channel 0 only is sent.
- The mask is sampled at frame start and held for the whole frame.
- Streaming continues indefinitely until the next sync_in.

STATUS:
- Bytes on successive edges: {5'b0, underrun, overflow, fifo_full}, then fifo_level zero-extended to 8 bits, then ovf_cnt.
- After the third byte: state=IDLE, bus_oe=0.
- Reading status does not clear flags.

Timing and reset:
- Pop-to-bus latency is 1 clock.
- reset_in mid-transfer returns everything to reset values immediately, asynchronously.

Test Plan:
1. CHANNELS=2, SAMPLE_BYTES=4. Push one frame (ch0 I=0x11223344, Q=0x55667788; ch1 I=0xAABBCCDD, Q=0x01020304), then STREAM -> bus_out sequence 55 66 77 88 11 22 33 44 01 02 03 04 AA BB CC DD. The following frame is all zeros and underrun=1.
2. SETMASK 0x02, push the frame from test 1, STREAM -> only 8 bytes per frame: 01 02 03 04 AA BB CC DD.
3. FIFO_DEPTH=8. Push 11 frames with no reads -> fifo_level=8, overflow=1. STATUS returns 0x03, 0x08, 0x03.
4. Full FIFO, with pop and iq_valid_in on the same cycle during STREAM -> fifo_level stays 8 and ovf_cnt is unchanged.
5. Push 300 frames into a full FIFO -> ovf_cnt=255. CLEAR, then STATUS -> 0x01, 0x08, 0x00.
6. Assert reset_in in the middle of a STREAM frame -> bus_oe=0, fifo_level=0 and flags cleared immediately. A subsequent STREAM outputs a zero frame and sets underrun.
